minimal_mem_initiator: RTL and testbench

//  Bus master for the Bambu minimal memory interface, one channel wide. It turns a valid/ready command

---
 rtl/minimal_mem_pkg.sv | 23 ++
 rtl/minimal_mem_initiator_if.sv | 47 ++++
 rtl/access_watchdog.sv | 30 +++
 rtl/minimal_mem_initiator.sv | 109 ++++++++++
 tb/tb_minimal_mem_initiator.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/minimal_mem_pkg.sv
// Shared types and helpers for the minimal memory interface initiator and responder models.
package minimal_mem_pkg;

    localparam int unsigned MASK_MAX_W = 64;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // Bit mask covering the low 'size' bits, clamped to data_w; size 0 gives an empty mask.
    function automatic logic [MASK_MAX_W-1:0] size_to_mask(input int unsigned size,
                                                           input int unsigned data_w);
        logic [MASK_MAX_W-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < MASK_MAX_W; i++) begin
            m[i] = (i < size) && (i < data_w);
        end
        return m;
    endfunction

endpackage

// File: rtl/minimal_mem_initiator_if.sv
// Command/response streams plus minimal-interface master bus for one channel.
interface minimal_mem_initiator_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned SIZE_W = 4
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_we;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic [SIZE_W-1:0] cmd_size;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    logic              Mout_oe_ram;
    logic              Mout_we_ram;
    logic [ADDR_W-1:0] Mout_addr_ram;
    logic [DATA_W-1:0] Mout_Wdata_ram;
    logic [SIZE_W-1:0] Mout_data_ram_size;
    logic [DATA_W-1:0] M_Rdata_ram;
    logic              M_DataRdy;

    // Initiator side.
    modport master (
        input  cmd_valid, cmd_we, cmd_addr, cmd_wdata, cmd_size,
        input  rsp_ready,
        input  M_Rdata_ram, M_DataRdy,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err,
        output Mout_oe_ram, Mout_we_ram, Mout_addr_ram, Mout_Wdata_ram, Mout_data_ram_size
    );

    // Host and responder side.
    modport slave (
        output cmd_valid, cmd_we, cmd_addr, cmd_wdata, cmd_size,
        output rsp_ready,
        output M_Rdata_ram, M_DataRdy,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err,
        input  Mout_oe_ram, Mout_we_ram, Mout_addr_ram, Mout_Wdata_ram, Mout_data_ram_size
    );

endinterface

// File: rtl/access_watchdog.sv
// Counts cycles a strobe has been held and flags the last permitted cycle.
module access_watchdog #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired_c
);
    localparam int unsigned     CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] SAT  = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] count;

    // Saturating cycle counter, cleared whenever no access is in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != SAT)) begin
            count <= count + CNT_W'(1);
        end
    end

    assign expired_c = enable && (count == LAST);

endmodule

// File: rtl/minimal_mem_initiator.sv
// Minimal memory interface bus master: command stream in, single access out, response stream back.
module minimal_mem_initiator #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned SIZE_W  = 4,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic                     clock,
    input  logic                     reset,
    minimal_mem_initiator_if.master  bus
);
    import minimal_mem_pkg::*;

    state_t            state;
    logic              rd_op;
    logic [DATA_W-1:0] mask_q;

    logic              accept_c;
    logic              done_c;
    logic [DATA_W-1:0] cmd_mask_c;
    logic [SIZE_W-1:0] cmd_size_c;
    logic              wd_clear_c;
    logic              wd_enable_c;
    logic              wd_expired_c;

    // Command decode: handshake, data mask and size clamped to the bus width.
    always_comb begin
        accept_c    = bus.cmd_valid && bus.cmd_ready;
        cmd_mask_c  = DATA_W'(size_to_mask(32'(bus.cmd_size), DATA_W));
        cmd_size_c  = (32'(bus.cmd_size) > DATA_W) ? SIZE_W'(DATA_W) : bus.cmd_size;
        wd_enable_c = (state == ACCESS);
        wd_clear_c  = (state != ACCESS);
        done_c      = bus.M_DataRdy || wd_expired_c;
    end

    access_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clock     (clock),
        .reset     (reset),
        .clear     (wd_clear_c),
        .enable    (wd_enable_c),
        .expired_c (wd_expired_c)
    );

    // Control FSM with registered stream and bus outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state                  <= IDLE;
            rd_op                  <= 1'b0;
            mask_q                 <= '0;
            bus.cmd_ready          <= 1'b0;
            bus.rsp_valid          <= 1'b0;
            bus.rsp_rdata          <= '0;
            bus.rsp_err            <= 1'b0;
            bus.Mout_oe_ram        <= 1'b0;
            bus.Mout_we_ram        <= 1'b0;
            bus.Mout_addr_ram      <= ADDR_W'(0);
            bus.Mout_Wdata_ram     <= '0;
            bus.Mout_data_ram_size <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept_c) begin
                        bus.cmd_ready          <= 1'b0;
                        bus.Mout_we_ram        <= bus.cmd_we;
                        bus.Mout_oe_ram        <= !bus.cmd_we;
                        bus.Mout_addr_ram      <= bus.cmd_addr;
                        bus.Mout_Wdata_ram     <= bus.cmd_wdata & cmd_mask_c;
                        bus.Mout_data_ram_size <= cmd_size_c;
                        rd_op                  <= !bus.cmd_we;
                        mask_q                 <= cmd_mask_c;
                        state                  <= ACCESS;
                    end else begin
                        bus.cmd_ready <= 1'b1;
                    end
                end
                ACCESS: begin
                    // Completion wins over a timeout landing on the same cycle.
                    if (done_c) begin
                        bus.Mout_oe_ram        <= 1'b0;
                        bus.Mout_we_ram        <= 1'b0;
                        bus.Mout_addr_ram      <= ADDR_W'(0);
                        bus.Mout_Wdata_ram     <= '0;
                        bus.Mout_data_ram_size <= '0;
                        bus.rsp_valid          <= 1'b1;
                        bus.rsp_err            <= !bus.M_DataRdy;
                        bus.rsp_rdata          <= (bus.M_DataRdy && rd_op) ?
                                                  (bus.M_Rdata_ram & mask_q) : '0;
                        state                  <= RESP;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        bus.rsp_rdata <= '0;
                        bus.rsp_err   <= 1'b0;
                        bus.cmd_ready <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_minimal_mem_initiator.sv
// Directed bench for minimal_mem_initiator with a transaction-level reference model.
module tb_minimal_mem_initiator;

    localparam int TIMEOUT = 16;

    logic clock = 1'b0;
    logic reset = 1'b0;

    minimal_mem_initiator_if #(.ADDR_W(8), .DATA_W(8), .SIZE_W(4)) bus ();

    minimal_mem_initiator #(
        .ADDR_W (8), .DATA_W (8), .SIZE_W (4), .TIMEOUT (TIMEOUT)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    endtask

    function automatic logic [7:0] mask_of(input int s);
        if (s >= 8) return 8'hFF;
        return 8'((1 << s) - 1);
    endfunction

    // ---------------- responder: raises DataRdy after rdy_wait strobe cycles (-1 = never)
    int          rdy_wait = 0;
    logic [7:0]  rd_value = 8'h00;
    int          rsp_k    = 0;
    always @(negedge clock) begin
        if (bus.Mout_oe_ram || bus.Mout_we_ram) begin
            rsp_k = rsp_k + 1;
            bus.M_DataRdy = (rdy_wait >= 0) && (rsp_k - 1 == rdy_wait);
        end else begin
            rsp_k = 0;
            bus.M_DataRdy = 1'b0;
        end
        bus.M_Rdata_ram = bus.M_DataRdy ? rd_value : 8'($urandom);
    end

    // Length of the most recent strobe burst, in cycles.
    int run_cnt  = 0;
    int last_run = 0;
    always @(posedge clock) begin
        if (bus.Mout_oe_ram || bus.Mout_we_ram) run_cnt = run_cnt + 1;
        else if (run_cnt != 0) begin
            last_run = run_cnt;
            run_cnt  = 0;
        end
    end

    // ---------------- reference model: one outstanding transaction and its response
    bit         m_ready, m_busy, m_rsp, m_err, m_we;
    int         m_age;
    logic [7:0] m_addr, m_wdata, m_rdata;
    logic [3:0] m_size;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_ready <= 0; m_busy <= 0; m_rsp <= 0; m_err <= 0; m_we <= 0;
            m_age <= 0; m_addr <= 0; m_wdata <= 0; m_rdata <= 0; m_size <= 0;
        end else if (m_rsp) begin
            if (bus.rsp_ready) begin
                m_rsp <= 0; m_rdata <= 0; m_err <= 0; m_ready <= 1;
            end
        end else if (m_busy) begin
            if (bus.M_DataRdy || (m_age + 1 >= TIMEOUT)) begin
                m_busy  <= 0;
                m_rsp   <= 1;
                m_err   <= !bus.M_DataRdy;
                m_rdata <= (bus.M_DataRdy && !m_we) ? (bus.M_Rdata_ram & mask_of(int'(m_size))) : 8'h00;
            end else begin
                m_age <= m_age + 1;
            end
        end else if (m_ready && bus.cmd_valid) begin
            m_busy <= 1; m_ready <= 0; m_age <= 0;
            m_we <= bus.cmd_we; m_addr <= bus.cmd_addr;
            m_wdata <= bus.cmd_wdata; m_size <= bus.cmd_size;
        end else begin
            m_ready <= 1;
        end
    end

    logic [32:0] act_vec, exp_vec;
    logic [3:0]  exp_sz;
    always @(negedge clock) begin
        if (chk_en) begin
            exp_sz  = (m_size > 4'd8) ? 4'd8 : m_size;
            act_vec = {bus.cmd_ready, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err,
                       bus.Mout_oe_ram, bus.Mout_we_ram, bus.Mout_addr_ram,
                       bus.Mout_Wdata_ram, bus.Mout_data_ram_size};
            exp_vec = {m_ready, m_rsp, m_rdata, m_err,
                       m_busy && !m_we, m_busy && m_we,
                       m_busy ? m_addr : 8'h00,
                       m_busy ? (m_wdata & mask_of(int'(m_size))) : 8'h00,
                       m_busy ? exp_sz : 4'd0};
            chk("cycle", 64'(act_vec), 64'(exp_vec));
        end
    end

    // ---------------- stimulus helpers
    logic [7:0] snap_addr, snap_wdata;
    logic [3:0] snap_size;
    bit         snap_oe, snap_we;

    task automatic issue(input bit we, input logic [7:0] a, input logic [7:0] d, input logic [3:0] s);
        bit ok;
        ok = 0;
        @(negedge clock);
        bus.cmd_we = we; bus.cmd_addr = a; bus.cmd_wdata = d; bus.cmd_size = s;
        bus.cmd_valid = 1'b1;
        for (int i = 0; i < 64 && !ok; i++) begin
            if (bus.cmd_ready) ok = 1;
            else @(negedge clock);
        end
        if (!ok) chk("accept_timeout", 0, 1);
        @(negedge clock);
        bus.cmd_valid = 1'b0;
        snap_oe = bus.Mout_oe_ram; snap_we = bus.Mout_we_ram;
        snap_addr = bus.Mout_addr_ram; snap_wdata = bus.Mout_Wdata_ram;
        snap_size = bus.Mout_data_ram_size;
    endtask

    task automatic wait_rsp(output logic [7:0] rd, output logic er);
        bit ok;
        ok = 0;
        for (int i = 0; i < 64 && !ok; i++) begin
            if (bus.rsp_valid) ok = 1;
            else @(negedge clock);
        end
        if (!ok) chk("rsp_timeout", 0, 1);
        rd = bus.rsp_rdata;
        er = bus.rsp_err;
    endtask

    // Lets the response handshake and the burst-length monitor settle.
    task automatic finish_rsp();
        @(negedge clock);
        @(negedge clock);
    endtask

    logic [7:0] r;
    logic       e;
    int         n;

    initial begin
        bus.cmd_valid = 0; bus.cmd_we = 0; bus.cmd_addr = 0; bus.cmd_wdata = 0; bus.cmd_size = 0;
        bus.rsp_ready = 1; bus.M_DataRdy = 0; bus.M_Rdata_ram = 0;

        // 1: reset held three cycles, then released
        #1 reset = 1'b1;
        chk_en = 1'b1;
        @(negedge clock);
        @(negedge clock);
        chk("reset_outputs", 64'({bus.cmd_ready, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err,
                                  bus.Mout_oe_ram, bus.Mout_we_ram, bus.Mout_addr_ram,
                                  bus.Mout_Wdata_ram, bus.Mout_data_ram_size}), 0);
        @(negedge clock);
        reset = 1'b0;
        #1 chk("ready_at_release", 64'(bus.cmd_ready), 0);
        @(negedge clock);
        chk("ready_after_edge", 64'(bus.cmd_ready), 1);

        // 2: write with one wait cycle
        rdy_wait = 1;
        issue(1'b1, 8'h20, 8'hA5, 4'd8);
        chk("wr_strobe", 64'({snap_we, snap_oe}), 64'(2'b10));
        chk("wr_addr", 64'(snap_addr), 64'h20);
        chk("wr_data", 64'(snap_wdata), 64'hA5);
        chk("wr_size", 64'(snap_size), 64'd8);
        wait_rsp(r, e);
        chk("wr_rdata", 64'(r), 0);
        chk("wr_err", 64'(e), 0);
        finish_rsp();
        chk("wr_we_cycles", 64'(last_run), 2);

        // 3: narrow read, then oversized read
        rdy_wait = 2; rd_value = 8'hFF;
        issue(1'b0, 8'h10, 8'h00, 4'd4);
        wait_rsp(r, e);
        chk("rd4_rdata", 64'(r), 64'h0F);
        chk("rd4_err", 64'(e), 0);
        finish_rsp();
        chk("rd4_oe_cycles", 64'(last_run), 3);
        issue(1'b0, 8'h10, 8'h00, 4'd12);
        chk("rd12_size", 64'(snap_size), 64'd8);
        wait_rsp(r, e);
        chk("rd12_rdata", 64'(r), 64'hFF);
        finish_rsp();

        // size 0 read masks everything; size 4 write masks upper nibble
        rdy_wait = 0;
        issue(1'b0, 8'h11, 8'h00, 4'd0);
        wait_rsp(r, e);
        chk("rd0_rdata", 64'(r), 0);
        finish_rsp();
        chk("rd0_zero_wait", 64'(last_run), 1);
        issue(1'b1, 8'h12, 8'hA5, 4'd4);
        chk("wr4_data", 64'(snap_wdata), 64'h05);
        wait_rsp(r, e);
        finish_rsp();

        // 4: timeout, then completion on the last permitted cycle
        rdy_wait = -1;
        issue(1'b0, 8'h33, 8'h00, 4'd8);
        wait_rsp(r, e);
        chk("to_err", 64'(e), 1);
        chk("to_rdata", 64'(r), 0);
        finish_rsp();
        chk("to_oe_cycles", 64'(last_run), 16);
        rdy_wait = 15; rd_value = 8'h3C;
        issue(1'b0, 8'h34, 8'h00, 4'd8);
        wait_rsp(r, e);
        chk("late_err", 64'(e), 0);
        chk("late_rdata", 64'(r), 64'h3C);
        finish_rsp();
        chk("late_oe_cycles", 64'(last_run), 16);

        // 5: response backpressure with next command waiting
        rdy_wait = 0; rd_value = 8'h81; bus.rsp_ready = 1'b0;
        issue(1'b0, 8'h44, 8'h00, 4'd8);
        wait_rsp(r, e);
        bus.cmd_we = 1'b1; bus.cmd_addr = 8'h55; bus.cmd_wdata = 8'h77; bus.cmd_size = 4'd8;
        bus.cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            chk("bp_hold", 64'({bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bus.cmd_ready, bus.Mout_we_ram}),
                64'({1'b1, 8'h81, 1'b0, 1'b0, 1'b0}));
        end
        bus.rsp_ready = 1'b1;
        n = 0;
        while (!bus.Mout_we_ram && n < 64) begin
            @(negedge clock);
            n++;
        end
        bus.cmd_valid = 1'b0;
        chk("bp_turnaround", 64'(n), 2);
        wait_rsp(r, e);
        finish_rsp();

        // 6: reset in the middle of a read access
        rdy_wait = -1;
        issue(1'b0, 8'h30, 8'h00, 4'd8);
        @(negedge clock);
        @(negedge clock);
        #2 reset = 1'b1;
        #1 chk("mid_reset_oe", 64'({bus.Mout_oe_ram, bus.rsp_valid}), 0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        n = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            if (bus.rsp_valid) n++;
        end
        chk("no_rsp_after_reset", 64'(n), 0);
        chk("idle_after_reset", 64'({bus.cmd_ready, bus.Mout_oe_ram}), 64'(2'b10));

        @(negedge clock);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout at %0t: got running expected finished", $time);
        $fatal(1);
    end

endmodule
